button_event_scheduler: RTL
===========================

// Module: button_event_scheduler
// PURPOSE
//  Debounces N_BTN raw active-low push buttons and queues their press/long-press events in a FIFO.
//  Buttons are served round-robin when several fire together.
//  Events leave on a valid/ready stream to the game FSM (feed, play, menu), so no event is lost while the FSM is busy.
// PARAMETERS
//  N_BTN       3    number of buttons (>=2); IW = $clog2(N_BTN)
//  DEB_CYCLES  16   consecutive stable samples to confirm a press or release (>=2)
//  HOLD_CYCLES 255  cycles in PRESSED/REL_CHK (counted after press confirm) before a long event (>DEB_CYCLES)
//  FIFO_DEPTH  4    event FIFO entries, power of two
// PORTS
//  clk       in   1      system clock; all state updates on posedge
//  rst_n     in   1      async active-low reset
//  b_in      in   N_BTN  raw buttons, 0 = pressed; pre-synchronised by 2-FF chain inside block
//  ev_valid  out  1      FIFO head holds an event
//  ev_ready  in   1      consumer accepts head this cycle
//  ev_btn    out  IW     button index of head event
//  ev_long   out  1      1 = long-press event, 0 = press event
//  b_hold    out  N_BTN  1 while button i is in PRESSED or REL_CHK
//  ev_drop   out  1      1-cycle pulse: event request lost (pending already set)
// BEHAVIOUR
//  Reset (async assert, sync-released use): all FSMs IDLE, counters 0, pending 0, FIFO empty, rr_ptr 0.
//    All outputs 0.
//  Per-button FSM (on synchronised sample s):
//    IDLE:     s==0 -> PRESS_CHK, deb_cnt=0.
//    PRESS_CHK: s==1 -> IDLE; deb_cnt==DEB_CYCLES-1 -> PRESSED, set press_pend, hold_cnt=0; else deb_cnt++.
//    PRESSED:  s==1 -> REL_CHK, deb_cnt=0; hold_cnt saturates at HOLD_CYCLES.
//      Reaching HOLD_CYCLES sets long_pend exactly once per press.
//    REL_CHK:  s==0 -> PRESSED (glitch, hold_cnt kept); deb_cnt==DEB_CYCLES-1 -> IDLE; else deb_cnt++.
//      hold_cnt keeps counting in REL_CHK.
//  Pending bits: 2*N_BTN request lines, order {long_i, press_i} per button.
//    A set request with its bit already 1 and not granted this cycle -> bit stays 1, ev_drop=1 for 1 cycle.
//    Set and grant in the same cycle -> bit stays 1 (new event kept, no drop).
//  Arbiter: when FIFO not full (or full with pop this cycle), grants one pending bit per cycle.
//    Round-robin over buttons starting at rr_ptr. Within a button, press before long.
//    rr_ptr <= granted button+1 (mod N_BTN).
//    The granted bit clears and {idx,long} is written to the FIFO tail on the same edge.
//  FIFO: ev_valid = !empty; head popped on edge with ev_valid&&ev_ready.
//    Push+pop when full allowed. Push+pop when empty: pushed entry becomes head next cycle.
//    ev_btn/ev_long hold stable while ev_valid && !ev_ready.
//  Latency (empty FIFO, no contention): press_pend set on confirm edge E; FIFO write at E+1; ev_valid=1 after E+1.
//    Raw edge to confirm = 2 sync + DEB_CYCLES cycles.
//  Pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1 distinguishes full/empty.
//  Mid-operation reset: queued and pending events discarded. A button held through reset re-debounces from IDLE.
// CONFIGURATION
//  BTN_LONG_PRESS_EN defined: hold_cnt, long_pend, long events as above.
//  Undefined: no hold counters/long_pend; ev_long tied 0; FIFO stores only index.
//    Arbiter rotates over N_BTN press bits.
// TESTING
//  1. Reset: rst_n=0 mid-run -> ev_valid=0, b_hold=0, ev_drop=0 immediately; FIFO empty after release.
//  2. Bounce: b_in[1] toggles every 5 cycles for 60 cycles, then stays 0.
//     -> single event btn=1 long=0; ev_valid rises 2+16+1 cycles after last toggle.
//  3. Simultaneous: b_in[0],b_in[2] fall same cycle, ev_ready=1.
//     -> events btn0 then btn2 on consecutive cycles; next tie after that serves btn0 first (rr_ptr=0).
//  4. Backpressure: ev_ready=0, 5 distinct press events.
//     -> FIFO holds 4, 5th stays pending; the next repeat request of that same bit -> ev_drop pulse.
//     ev_ready=1 drains 5 events in order.
//  5. Long press (EN defined): hold b_in[1]=0 for 400 cycles -> press event, then exactly one long event (btn=1, long=1).
//     Release -> b_hold[1] falls 16 cycles after synced release.
//  6. EN undefined: same stimulus as 5 -> only the press event; ev_long=0 always.

Source files
------------

// File: rtl/button_event_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// button_event_scheduler : debounces active-low buttons, arbitrates their events
// round-robin into a valid/ready FIFO. Define BTN_LONG_PRESS_EN for long events.
// Revision: 1.0
// -----------------------------------------------------------------------------
module button_event_scheduler #(
  parameter int N_BTN       = 3,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 255,
  parameter int FIFO_DEPTH  = 4,
  localparam int IW = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] b_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IW-1:0]    ev_btn,
  output logic             ev_long,
  output logic [N_BTN-1:0] b_hold,
  output logic             ev_drop
);

`ifdef BTN_LONG_PRESS_EN
  localparam int RPB = 2;
`else
  localparam int RPB = 1;
`endif
  localparam int NREQ = N_BTN * RPB;
  localparam int EW   = IW + RPB - 1;
  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } btn_state_e;

  if (N_BTN < 2 || DEB_CYCLES < 2 || HOLD_CYCLES <= DEB_CYCLES || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("button_event_scheduler: invalid parameter set");
  end

  // Synchronisers reset to the released level so reset never looks like a press.
  logic [N_BTN-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= b_in;
      sync2_q <= sync1_q;
    end
  end

  logic [NREQ-1:0] req_set;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_e    state_q;
    logic [DW-1:0] deb_q;
    logic          s;
    logic          press_set;

    assign s = sync2_q[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        deb_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (!s) begin
            state_q <= ST_PRESS_CHK;
            deb_q   <= '0;
          end
          ST_PRESS_CHK: begin
            if (s)                      state_q <= ST_IDLE;
            else if (deb_q == DEB_LAST) state_q <= ST_PRESSED;
            else                        deb_q   <= deb_q + DW'(1);
          end
          ST_PRESSED: if (s) begin
            state_q <= ST_REL_CHK;
            deb_q   <= '0;
          end
          ST_REL_CHK: begin
            if (!s)                     state_q <= ST_PRESSED;
            else if (deb_q == DEB_LAST) state_q <= ST_IDLE;
            else                        deb_q   <= deb_q + DW'(1);
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign press_set = (state_q == ST_PRESS_CHK) && !s && (deb_q == DEB_LAST);
    assign b_hold[i] = (state_q == ST_PRESSED) || (state_q == ST_REL_CHK);

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    logic [HW-1:0] hold_cnt_q;
    logic          long_set;

    // Saturating counter: the step onto HOLD_CYCLES happens once per press.
    assign long_set = b_hold[i] && (hold_cnt_q == HW'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        hold_cnt_q <= '0;
      else if (press_set)
        hold_cnt_q <= '0;
      else if (b_hold[i] && hold_cnt_q != HW'(HOLD_CYCLES))
        hold_cnt_q <= hold_cnt_q + HW'(1);
    end

    assign req_set[2*i]   = press_set;
    assign req_set[2*i+1] = long_set;
`else
    assign req_set[i] = press_set;
`endif
  end

  logic [NREQ-1:0] pend_q, pend_d, grant;
  logic            grant_any;
  logic [IW-1:0]   grant_btn;
  logic [IW-1:0]   rr_q;
  logic            drop_d, ev_drop_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   wr_q, rd_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   wr_data, head;
  logic            fifo_full, pop, can_push;

  assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
  assign ev_valid  = (cnt_q != '0);
  assign pop       = ev_valid && ev_ready;
  assign can_push  = !fifo_full || pop;

  // Request bits are laid out button-major, so rotating from rr_q*RPB gives
  // button round-robin with press ahead of long inside each button.
`ifdef BTN_LONG_PRESS_EN
  logic grant_long;
`endif
  always_comb begin
    int j;
    grant     = '0;
    grant_any = 1'b0;
    grant_btn = '0;
`ifdef BTN_LONG_PRESS_EN
    grant_long = 1'b0;
`endif
    j = 0;
    if (can_push) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (int'(rr_q) * RPB + k) % NREQ;
        if (!grant_any && pend_q[j]) begin
          grant_any = 1'b1;
          grant[j]  = 1'b1;
          grant_btn = IW'(j / RPB);
`ifdef BTN_LONG_PRESS_EN
          grant_long = (j % RPB) == 1;
`endif
        end
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  assign wr_data = {grant_btn, grant_long};
`else
  assign wr_data = grant_btn;
`endif

  assign pend_d = (pend_q & ~grant) | req_set;
  assign drop_d = |(req_set & pend_q & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      rr_q      <= '0;
      ev_drop_q <= 1'b0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      pend_q    <= pend_d;
      ev_drop_q <= drop_d;
      if (grant_any) begin
        mem_q[wr_q] <= wr_data;
        wr_q        <= wr_q + AW'(1);
        rr_q        <= (grant_btn == IW'(N_BTN - 1)) ? '0 : grant_btn + IW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({grant_any, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head    = mem_q[rd_q];
  assign ev_drop = ev_drop_q;
`ifdef BTN_LONG_PRESS_EN
  assign ev_btn  = ev_valid ? head[EW-1:1] : '0;
  assign ev_long = ev_valid & head[0];
`else
  assign ev_btn  = ev_valid ? head : '0;
  assign ev_long = 1'b0;
`endif

endmodule
`default_nettype wire
